// File: rtl/scan_pattern_ctrl_pkg.sv
// Shared types and constants for the scan pattern controller (package scan_pkg).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

    // x^32 + x^22 + x^2 + x + 1, x^32 implied
    localparam logic [31:0] SCAN_POLY      = 32'h0040_0007;
    localparam logic [31:0] SCAN_LFSR_SEED = 32'hACE1_2468;

    localparam int PI_W = 36;
    localparam int PO_W = 39;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        SHIFT,
        UNLOAD,
        DONE
    } scan_state_t;

    // Fold the 39 primary outputs onto 32 bits for parallel MISR compaction.
    function automatic logic [31:0] po_fold(input logic [PO_W-1:0] po);
        return po[31:0] ^ {25'b0, po[PO_W-1:32]};
    endfunction

endpackage

// File: rtl/scan_pattern_ctrl_if.sv
// Scan-side bundle between the controller and the scan-inserted core.
// Latency: n/a (wires only).
// Backpressure: none; the core follows scan_en every cycle.
// Ports: scan_en/scan_in/pi_vec (controller -> core), scan_out/po_vec (core -> controller).
interface scan_pattern_ctrl_if;
    import scan_pkg::*;

    logic            scan_en;
    logic            scan_in;
    logic            scan_out;
    logic [PI_W-1:0] pi_vec;
    logic [PO_W-1:0] po_vec;

    modport master (
        output scan_en,
        output scan_in,
        output pi_vec,
        input  scan_out,
        input  po_vec
    );

    modport slave (
        input  scan_en,
        input  scan_in,
        input  pi_vec,
        output scan_out,
        output po_vec
    );

endinterface

// File: rtl/scan_pattern_ctrl_lfsr32.sv
// 32-bit shift register on SCAN_POLY: Fibonacci right-shift generator or serial MISR.
// Latency: q updates one cycle after load/step; q_nxt is the combinational next value.
// Backpressure: none; step is an enable, load has priority over step.
// Ports: CK/RST, load/load_val, step, sin (MISR serial in), par_in (MISR parallel XOR), q, q_nxt.
module scan_lfsr32
    import scan_pkg::*;
#(
    parameter bit          MISR_MODE = 1'b0,
    parameter logic [31:0] RST_VAL   = 32'h0
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    input  logic        sin,
    input  logic [31:0] par_in,
    output logic [31:0] q,
    output logic [31:0] q_nxt
);

    always_comb begin
        q_nxt = q;
        if (load) begin
            q_nxt = load_val;
        end else if (step) begin
            if (MISR_MODE) begin
                q_nxt = {q[30:0], 1'b0} ^ (q[31] ? SCAN_POLY : 32'h0)
                      ^ {31'b0, sin} ^ par_in;
            end else begin
                // With q[i] holding sequence bit n+i, the recurrence taps are
                // exactly the non-leading polynomial terms, i.e. SCAN_POLY.
                q_nxt = {^(q & SCAN_POLY), q[31:1]};
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            q <= RST_VAL;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/scan_pattern_ctrl.sv
// Scan test controller: LFSR scan loads and PI vectors, shift/capture sequencing, serial MISR.
// Latency: busy one cycle after start; busy lasts CHAIN_LEN + N*(CHAIN_LEN+1) cycles, then done.
// Backpressure: none; start is ignored unless IDLE. Macro SCAN_PO_COMPACT_EN folds po_vec into the MISR.
// Ports: CK/RST, start/num_patterns (run request), scan (core-side bundle), busy/done/signature.
module scan_pattern_ctrl
    import scan_pkg::*;
#(
    parameter int          CHAIN_LEN = 211,
    parameter int          NPAT_W    = 16,
    parameter logic [31:0] LFSR_SEED = SCAN_LFSR_SEED
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                start,
    input  logic [NPAT_W-1:0]   num_patterns,
    scan_pattern_ctrl_if.master scan,
    output logic                busy,
    output logic                done,
    output logic [31:0]         signature
);

    localparam int               CNT_W      = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

    scan_state_t       state, state_d;
    logic [CNT_W-1:0]  shift_cnt, shift_cnt_d;
    logic [NPAT_W-1:0] pat_cnt, pat_cnt_d;
    logic [NPAT_W-1:0] npat, npat_d;

    logic        lfsr_load, lfsr_step;
    logic        misr_load, misr_step, misr_sin;
    logic        cap_step;
    logic [31:0] misr_par;
    logic [31:0] lfsr_nxt;
    logic [31:0] lfsr_q_unused;
    logic [31:0] misr_nxt_unused;

    logic            scan_en_q, scan_in_q;
    logic [PI_W-1:0] pi_q;

`ifdef SCAN_PO_COMPACT_EN
    // CAPTURE takes a normal MISR step (serial input 0) plus the folded POs.
    assign cap_step = 1'b1;
    assign misr_par = (state == CAPTURE) ? po_fold(scan.po_vec) : 32'h0;
`else
    logic po_unused;
    assign cap_step  = 1'b0;
    assign misr_par  = 32'h0;
    assign po_unused = ^scan.po_vec;
`endif

    always_comb begin
        state_d     = state;
        shift_cnt_d = shift_cnt;
        pat_cnt_d   = pat_cnt;
        npat_d      = npat;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        misr_load   = 1'b0;
        misr_step   = 1'b0;
        misr_sin    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    npat_d      = num_patterns;
                    lfsr_load   = 1'b1;
                    misr_load   = 1'b1;
                    shift_cnt_d = '0;
                    pat_cnt_d   = '0;
                    state_d     = (num_patterns == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // Chain holds post-reset junk on the first load: MISR stays frozen.
                lfsr_step = 1'b1;
                if (shift_cnt == LAST_SHIFT) begin
                    shift_cnt_d = '0;
                    state_d     = CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt + CNT_W'(1);
                end
            end
            CAPTURE: begin
                pat_cnt_d = pat_cnt + NPAT_W'(1);
                misr_step = cap_step;
                state_d   = (pat_cnt_d == npat) ? UNLOAD : SHIFT;
            end
            SHIFT: begin
                lfsr_step = 1'b1;
                misr_step = 1'b1;
                misr_sin  = scan.scan_out;
                if (shift_cnt == LAST_SHIFT) begin
                    shift_cnt_d = '0;
                    state_d     = CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt + CNT_W'(1);
                end
            end
            UNLOAD: begin
                misr_step = 1'b1;
                misr_sin  = scan.scan_out;
                if (shift_cnt == LAST_SHIFT) begin
                    shift_cnt_d = '0;
                    state_d     = DONE;
                end else begin
                    shift_cnt_d = shift_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // phase they describe; scan_in/pi_vec use the LFSR's next value for the
    // same reason.
    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            npat      <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            pi_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            shift_cnt <= shift_cnt_d;
            pat_cnt   <= pat_cnt_d;
            npat      <= npat_d;
            scan_en_q <= state_d inside {LOAD, SHIFT, UNLOAD};
            scan_in_q <= (state_d inside {LOAD, SHIFT}) ? lfsr_nxt[0] : 1'b0;
            if (state_d == CAPTURE) begin
                pi_q <= {lfsr_nxt[3:0], lfsr_nxt};
            end
            busy      <= state_d inside {LOAD, CAPTURE, SHIFT, UNLOAD};
            done      <= (state_d == DONE);
        end
    end

    assign scan.scan_en = scan_en_q;
    assign scan.scan_in = scan_in_q;
    assign scan.pi_vec  = pi_q;

    scan_lfsr32 #(
        .MISR_MODE (1'b0),
        .RST_VAL   (LFSR_SEED)
    ) u_lfsr (
        .CK       (CK),
        .RST      (RST),
        .load     (lfsr_load),
        .load_val (LFSR_SEED),
        .step     (lfsr_step),
        .sin      (1'b0),
        .par_in   (32'h0),
        .q        (lfsr_q_unused),
        .q_nxt    (lfsr_nxt)
    );

    scan_lfsr32 #(
        .MISR_MODE (1'b1),
        .RST_VAL   (32'h0)
    ) u_misr (
        .CK       (CK),
        .RST      (RST),
        .load     (misr_load),
        .load_val (32'h0),
        .step     (misr_step),
        .sin      (misr_sin),
        .par_in   (misr_par),
        .q        (signature),
        .q_nxt    (misr_nxt_unused)
    );

endmodule
